// File: rtl/tt_sweep.sv
// tt_sweep: steps a 4-input function through all 16 vectors, dwelling DWELL cycles on each, and captures its truth table.
// Define TT_SWEEP_CMP_EN to also compare the captured table against exp_table.
module tt_sweep #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f,
  input  logic [15:0] exp_table,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [15:0] table_o,
  output logic        busy,
  output logic        done,
  output logic        table_valid,
  output logic        mismatch
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  state_t      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  vec_q;
  logic [7:0]  cnt_q;
  logic [15:0] table_q;
  logic [15:0] table_d;
  logic        busy_q;
  logic        done_q;
  logic        valid_q;
  logic        last_sample;
  always_comb begin
    table_d = table_q;
    table_d[idx_q] = f;
  end
  // The final sample of a sweep: abort wins over it at the same edge.
  assign last_sample = (state_q == RUN) && !abort && (cnt_q == LAST) && (idx_q == 4'd15);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      vec_q   <= 4'd0;
      cnt_q   <= 8'd0;
      table_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          idx_q   <= 4'd0;
          vec_q   <= 4'd0;
          cnt_q   <= 8'd0;
          table_q <= 16'h0000;
          busy_q  <= 1'b1;
          valid_q <= 1'b0;
        end
        RUN: if (abort) begin
          state_q <= IDLE;
          vec_q   <= 4'd0;
          busy_q  <= 1'b0;
        end else if (cnt_q == LAST) begin
          table_q <= table_d;
          cnt_q   <= 8'd0;
          if (idx_q == 4'd15) begin
            state_q <= DONE;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 4'd1;
            vec_q <= idx_q + 4'd1;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {a, b, c, d} = vec_q;
  assign table_o      = table_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_valid  = valid_q;
`ifdef TT_SWEEP_CMP_EN
  logic mismatch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mismatch_q <= 1'b0;
    else if (state_q == IDLE && start)
      mismatch_q <= 1'b0;
    else if (last_sample)
      mismatch_q <= table_d != exp_table;
  end
  assign mismatch = mismatch_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^exp_table ^ last_sample;
  assign mismatch   = 1'b0;
`endif
endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: directed sweeps with a done-driven scoreboard monitor for tt_sweep.
module tb_tt_sweep;
`ifdef TT_SWEEP_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        f;
  logic [15:0] exp_table = 16'hF888;
  logic        a, b, c, d;
  logic [15:0] table_o;
  logic        busy, done, table_valid, mismatch;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  typedef struct {
    logic [15:0] tbl;
    logic        mm;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  tt_sweep #(.DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f),
    .exp_table(exp_table), .a(a), .b(b), .c(c), .d(d), .table_o(table_o),
    .busy(busy), .done(done), .table_valid(table_valid), .mismatch(mismatch)
  );
  assign f = (a & b) | (c & d);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, expv, $time);
    end
  endtask
  task automatic chk_all_zero(input string n);
    chk({n, "_vec"}, {a, b, c, d}, 0);
    chk({n, "_table"}, table_o, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_valid"}, table_valid, 0);
    chk({n, "_mismatch"}, mismatch, 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_table", table_o, e.tbl);
        chk("done_valid", table_valid, 1);
        chk("done_mismatch", mismatch, e.mm);
        chk("done_busy", busy, 0);
      end
    end
  end
  task automatic sweep(input logic [15:0] et, input bit repulse, input bit with_abort);
    logic mm;
    mm = CMP && (et != 16'hF888);
    exp_table = et;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    sb.push_back('{tbl: 16'hF888, mm: mm, cyc: cyc + 64});
    for (int k = 0; k < 64; k++) begin
      chk("trace_vec", {a, b, c, d}, k / 4);
      chk("trace_busy", busy, 1);
      chk("trace_done", done, 0);
      chk("trace_valid", table_valid, 0);
      chk("trace_mismatch", mismatch, 0);
      if (k == 0) chk("start_clears_table", table_o, 0);
      if (repulse && (k == 10 || k == 40)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_vec", {a, b, c, d}, 0);
    chk("done_busy_low", busy, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("post_done", done, 0);
    chk("post_valid", table_valid, 1);
    chk("post_mismatch", mismatch, mm);
    chk("post_table", table_o, 16'hF888);
    chk("post_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", table_valid, 1);
    chk("hold_mismatch", mismatch, mm);
  endtask
  initial begin
    #2;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sweep(16'hF888, 1'b0, 1'b0);
    sweep(16'hF880, 1'b1, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vec", {a, b, c, d}, 0);
    chk("abort_valid", table_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_partial_table", table_o, 16'h0008);
    repeat (70) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("held_reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("after_reset_done", done, 0);
    sweep(16'hF888, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
